// File: rtl/tic_tac_toe_move_sequencer_pkg.sv
// Shared types for the tic-tac-toe move sequencer: board game-state codes,
// response error codes, sequencer state encoding and the cell index helper.
package ttt_pkg;

  typedef enum logic [1:0] {
    GS_PLAY = 2'b00,
    GS_XWON = 2'b01,
    GS_OWON = 2'b10,
    GS_DRAW = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_COORD = 2'b01,
    ERR_OCC   = 2'b10,
    ERR_OVER  = 2'b11
  } resp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETTLE,
    ST_OVER
  } seq_state_e;

  // Maps 1-based row/col (01..11) to the occupancy bit index 0..8.
  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = {2'b00, row} - 4'd1;
    c = {2'b00, col} - 4'd1;
    return (r * 4'd3) + c;
  endfunction

endpackage

// File: rtl/tic_tac_toe_move_sequencer_if.sv
// Move request / response channel between a player front-end (master)
// and the move sequencer (slave).
interface tic_tac_toe_move_sequencer_if;
  import ttt_pkg::*;

  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_row;
  logic [1:0] move_col;
  logic       resp_valid;
  resp_err_e  resp_err;

  modport master (
    output move_valid, move_row, move_col,
    input  move_ready, resp_valid, resp_err
  );

  modport slave (
    input  move_valid, move_row, move_col,
    output move_ready, resp_valid, resp_err
  );

endinterface

// File: rtl/tic_tac_toe_move_sequencer_turn_timer.sv
// Per-turn idle counter. Counts while enabled, clears on request, and
// flags expiry in the cycle it would count past TURN_TIMEOUT-1.
module ttt_turn_timer #(
  parameter int unsigned TURN_TIMEOUT = 1,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TURN_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: clear wins over increment; hold otherwise.
  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/tic_tac_toe_move_sequencer.sv
// Front-end for the 3x3 board: validates move requests against board
// occupancy and game state, issues legal moves as a one-cycle set pulse,
// tracks turn/move count and an optional per-turn forfeit timer.
module tic_tac_toe_move_sequencer
  import ttt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TURN_TIMEOUT  = 0,
  parameter int unsigned TIMER_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  tic_tac_toe_move_sequencer_if.slave        mv,
  input  logic [8:0]                         board_valid,
  input  logic [1:0]                         game_state,
  output logic                               set_o,
  output logic [1:0]                         row_o,
  output logic [1:0]                         col_o,
  output logic                               cur_player,
  output logic [3:0]                         moves_made,
  output logic                               timeout
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  seq_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic       set_q, set_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [1:0] req_row_q, req_row_d, req_col_q, req_col_d;
  logic [3:0] settle_q, settle_d;
  logic       resp_valid_q, resp_valid_d;
  resp_err_e  resp_err_q, resp_err_d;
  logic       player_q, player_d;
  logic [3:0] moves_q, moves_d;
  logic       timeout_q, timeout_d;
  logic       over_acc_q, over_acc_d;

  logic hs, in_play, coord_bad, occupied, settle_done, timer_expire;

  assign hs          = mv.move_valid && ready_q;
  assign in_play     = (game_state == GS_PLAY);
  assign coord_bad   = (req_row_q == 2'b00) || (req_col_q == 2'b00);
  assign occupied    = board_valid[cell_idx(req_row_q, req_col_q)];
  assign settle_done = (state_q == ST_SETTLE) && (settle_q == 4'd1);

  // Timer exists only when forfeits are enabled; it idles outside IDLE.
  if (TURN_TIMEOUT > 0) begin : g_timer
    ttt_turn_timer #(
      .TURN_TIMEOUT(TURN_TIMEOUT),
      .TIMER_W     (TIMER_W)
    ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (settle_done),
      .en_i    ((state_q == ST_IDLE) && !hs),
      .expire_o(timer_expire)
    );
  end else begin : g_no_timer
    assign timer_expire = 1'b0;
  end

  // State and registered-output flops; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      set_q        <= 1'b0;
      row_q        <= 2'b00;
      col_q        <= 2'b00;
      req_row_q    <= 2'b00;
      req_col_q    <= 2'b00;
      settle_q     <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= ERR_OK;
      player_q     <= 1'b0;
      moves_q      <= 4'd0;
      timeout_q    <= 1'b0;
      over_acc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      set_q        <= set_d;
      row_q        <= row_d;
      col_q        <= col_d;
      req_row_q    <= req_row_d;
      req_col_q    <= req_col_d;
      settle_q     <= settle_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      player_q     <= player_d;
      moves_q      <= moves_d;
      timeout_q    <= timeout_d;
      over_acc_q   <= over_acc_d;
    end
  end

  // Next state: an accepted handshake in IDLE beats game-over and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs)                           state_d = ST_CHECK;
        else if (!in_play || timer_expire) state_d = ST_OVER;
      end
      ST_CHECK: begin
        if (!in_play)                    state_d = ST_OVER;
        else if (coord_bad || occupied)  state_d = ST_IDLE;
        else                             state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) state_d = in_play ? ST_IDLE : ST_OVER;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs and datapath state.
  always_comb begin
    ready_d      = (state_d == ST_IDLE) || (state_d == ST_OVER);
    set_d        = 1'b0;
    row_d        = row_q;
    col_d        = col_q;
    req_row_d    = req_row_q;
    req_col_d    = req_col_q;
    settle_d     = settle_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    player_d     = player_q;
    moves_d      = moves_q;
    timeout_d    = timeout_q;
    over_acc_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          req_row_d = mv.move_row;
          req_col_d = mv.move_col;
        end else if (timer_expire) begin
          timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        resp_valid_d = 1'b1;
        if (!in_play) begin
          resp_err_d = ERR_OVER;
        end else if (coord_bad) begin
          resp_err_d = ERR_COORD;
        end else if (occupied) begin
          resp_err_d = ERR_OCC;
        end else begin
          resp_valid_d = 1'b0;
          set_d        = 1'b1;
          row_d        = req_row_q;
          col_d        = req_col_q;
          settle_d     = SETTLE_INIT;
        end
      end
      ST_SETTLE: begin
        if (settle_done) begin
          settle_d     = 4'd0;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_OK;
          player_d     = ~player_q;
          if (moves_q != 4'd9) moves_d = moves_q + 4'd1;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_OVER: begin
        // Requests after game over are answered one cycle after acceptance.
        over_acc_d = hs;
        if (over_acc_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_OVER;
        end
      end
      default: ;
    endcase
  end

  assign mv.move_ready = ready_q;
  assign mv.resp_valid = resp_valid_q;
  assign mv.resp_err   = resp_err_q;
  assign set_o         = set_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign cur_player    = player_q;
  assign moves_made    = moves_q;
  assign timeout       = timeout_q;

endmodule
